// File: rtl/fpmul_pkg.sv
// Shared types and constants for the floating-point multiplier arbiter.
package fpmul_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/fpmul_tag_pipe.sv
// LATENCY-deep shift register of {valid, id} tags that tracks which requester
// owns each multiplier stage; asynchronous clear drops everything in flight.
module fpmul_tag_pipe
  import fpmul_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tail,
  output logic o_any_valid
);

  tag_t r_stage [LATENCY];

  // Advance every tag one stage per cycle; reset discards all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < LATENCY; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // Reduce stage valids so the owner can tell when the pipe is empty.
  always_comb begin
    o_any_valid = 1'b0;
    for (int k = 0; k < LATENCY; k++) o_any_valid = o_any_valid | r_stage[k].valid;
  end

  assign o_tail = r_stage[LATENCY-1];

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one fixed-latency FP multiplier between two
// requesters, with in-order result return and a drain handshake.
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int FP_W    = fpmul_pkg::FP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            req1_ready,
  output logic [FP_W-1:0] mul_a,
  output logic [FP_W-1:0] mul_b,
  output logic            mul_issue,
  input  logic [FP_W-1:0] mul_result,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [FP_W-1:0] rsp_data,
  input  logic            drain,
  output logic            drained,
  output logic            busy
);

  state_t          r_state, w_state_nxt;
  logic            r_last;
  logic            r_mul_issue, r_mul_id;
  logic [FP_W-1:0] r_mul_a, r_mul_b, r_rsp_data;
  logic            r_rsp0, r_rsp1;
  logic            w_grant_ok, w_hs0, w_hs1, w_hs;
  logic            w_tags_busy, w_busy, w_drained;
  tag_t            w_tag_in, w_tail;

  // Grants only while running and not being asked to drain; on a tie the
  // requester that did not win last time goes first (r_last = last winner).
  assign w_grant_ok = (r_state == RUN) && !drain;
  assign req0_ready = w_grant_ok && req0_valid && (!req1_valid || r_last);
  assign req1_ready = w_grant_ok && req1_valid && (!req0_valid || !r_last);
  assign w_hs0      = req0_valid && req0_ready;
  assign w_hs1      = req1_valid && req1_ready;
  assign w_hs       = w_hs0 || w_hs1;

  // Issue register: capture the winner's operands and remember who won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_issue <= 1'b0;
      r_mul_id    <= 1'b0;
      r_last      <= 1'b1;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_mul_issue <= w_hs;
      if (w_hs) begin
        r_mul_a  <= w_hs1 ? req1_a : req0_a;
        r_mul_b  <= w_hs1 ? req1_b : req0_b;
        r_mul_id <= w_hs1;
        r_last   <= w_hs1;
      end
    end
  end

  // The tag enters one cycle after the handshake, alongside mul_issue, so the
  // tail lines up with mul_result LATENCY cycles later.
  assign w_tag_in = {r_mul_issue, r_mul_id};

  fpmul_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tag      (w_tag_in),
    .o_tail     (w_tail),
    .o_any_valid(w_tags_busy)
  );

  // Response register: latch the product and strobe the owning requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0     <= 1'b0;
      r_rsp1     <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_rsp0 <= w_tail.valid && !w_tail.id;
      r_rsp1 <= w_tail.valid &&  w_tail.id;
      if (w_tail.valid) r_rsp_data <= mul_result;
    end
  end

  assign w_busy = w_tags_busy || r_mul_issue || r_rsp0 || r_rsp1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state; drained fires in the first DRAIN cycle with nothing in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_drained   = 1'b0;
    case (r_state)
      RUN:   if (drain) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!w_busy) begin
          w_drained   = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_issue  = r_mul_issue;
  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign rsp_data   = r_rsp_data;
  assign drained    = w_drained;
  assign busy       = w_busy;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter: two builds (LATENCY=4 and LATENCY=1)
// share the same stimulus, each with its own behavioural multiplier.
module tb_fpmul_arbiter;

  localparam int LAT [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, drain;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_rdy [2];
  logic        req1_rdy [2];
  logic [31:0] mul_a_o  [2];
  logic [31:0] mul_b_o  [2];
  logic        mul_iss  [2];
  logic        rsp0_v   [2];
  logic        rsp1_v   [2];
  logic [31:0] rsp_d    [2];
  logic        drained_o[2];
  logic        busy_o   [2];

  logic [31:0] mp4 [4];
  logic [31:0] mp1;

  int total = 0;
  int bad   = 0;

  logic [31:0] btab [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
  logic [31:0] etab [10] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000,
                             32'h41400000, 32'h41600000, 32'h41800000, 32'h41900000, 32'h41A00000};

  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, m;
    logic [9:0]  e;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    m  = ma * mb;
    e  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    if (m[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, m[46:24]};
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  always_ff @(posedge clk) begin
    mp4[0] <= fmul(mul_a_o[0], mul_b_o[0]);
    mp4[1] <= mp4[0];
    mp4[2] <= mp4[1];
    mp4[3] <= mp4[2];
    mp1    <= fmul(mul_a_o[1], mul_b_o[1]);
  end

  fpmul_arbiter #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_rdy[0]),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_rdy[0]),
    .mul_a(mul_a_o[0]), .mul_b(mul_b_o[0]), .mul_issue(mul_iss[0]), .mul_result(mp4[3]),
    .rsp0_valid(rsp0_v[0]), .rsp1_valid(rsp1_v[0]), .rsp_data(rsp_d[0]),
    .drain(drain), .drained(drained_o[0]), .busy(busy_o[0])
  );

  fpmul_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_rdy[1]),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_rdy[1]),
    .mul_a(mul_a_o[1]), .mul_b(mul_b_o[1]), .mul_issue(mul_iss[1]), .mul_result(mp1),
    .rsp0_valid(rsp0_v[1]), .rsp1_valid(rsp1_v[1]), .rsp_data(rsp_d[1]),
    .drain(drain), .drained(drained_o[1]), .busy(busy_o[1])
  );

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; drain = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++; if (mul_iss[d] !== 1'b0) begin bad++; $display("FAIL reset_mul_issue dut%0d got=%b exp=0", d, mul_iss[d]); end
      total++; if (rsp0_v[d] !== 1'b0) begin bad++; $display("FAIL reset_rsp0 dut%0d got=%b exp=0", d, rsp0_v[d]); end
      total++; if (rsp1_v[d] !== 1'b0) begin bad++; $display("FAIL reset_rsp1 dut%0d got=%b exp=0", d, rsp1_v[d]); end
      total++; if (drained_o[d] !== 1'b0) begin bad++; $display("FAIL reset_drained dut%0d got=%b exp=0", d, drained_o[d]); end
      total++; if (busy_o[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy_o[d]); end
      total++; if (mul_a_o[d] !== 32'h0) begin bad++; $display("FAIL reset_mul_a dut%0d got=%h exp=0", d, mul_a_o[d]); end
      total++; if (mul_b_o[d] !== 32'h0) begin bad++; $display("FAIL reset_mul_b dut%0d got=%h exp=0", d, mul_b_o[d]); end
      total++; if (rsp_d[d] !== 32'h0) begin bad++; $display("FAIL reset_rsp_data dut%0d got=%h exp=0", d, rsp_d[d]); end
      total++; if (req0_rdy[d] !== 1'b0 || req1_rdy[d] !== 1'b0) begin bad++; $display("FAIL reset_ready dut%0d got=%b%b exp=00", d, req0_rdy[d], req1_rdy[d]); end
    end
    req1_valid = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++; if (req1_rdy[d] !== 1'b1 || req0_rdy[d] !== 1'b0) begin bad++; $display("FAIL reset_ready_rule dut%0d got r0=%b r1=%b exp r0=0 r1=1", d, req0_rdy[d], req1_rdy[d]); end
    end
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic e;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++; if (req0_rdy[d] !== 1'b1 || req1_rdy[d] !== 1'b0) begin bad++; $display("FAIL single_ready dut%0d got r0=%b r1=%b exp r0=1 r1=0", d, req0_rdy[d], req1_rdy[d]); end
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        e = (i == 1);
        total++; if (mul_iss[d] !== e) begin bad++; $display("FAIL single_issue dut%0d i=%0d got=%b exp=%b", d, i, mul_iss[d], e); end
        if (i == 1) begin
          total++; if (mul_a_o[d] !== 32'h40000000 || mul_b_o[d] !== 32'h40400000) begin bad++; $display("FAIL single_operands dut%0d got=%h/%h exp=40000000/40400000", d, mul_a_o[d], mul_b_o[d]); end
        end
        e = (i == LAT[d] + 2);
        total++; if (rsp0_v[d] !== e) begin bad++; $display("FAIL single_rsp0 dut%0d i=%0d got=%b exp=%b", d, i, rsp0_v[d], e); end
        total++; if (rsp1_v[d] !== 1'b0) begin bad++; $display("FAIL single_rsp1 dut%0d i=%0d got=%b exp=0", d, i, rsp1_v[d]); end
        if (e) begin
          total++; if (rsp_d[d] !== 32'h40C00000) begin bad++; $display("FAIL single_data dut%0d got=%h exp=40C00000", d, rsp_d[d]); end
        end
        e = (i <= LAT[d] + 2);
        total++; if (busy_o[d] !== e) begin bad++; $display("FAIL single_busy dut%0d i=%0d got=%b exp=%b", d, i, busy_o[d], e); end
      end
    end
  endtask

  task automatic test_contention();
    logic e0, e1;
    int   g;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0_a = 32'h40000000; req0_b = 32'h40400000;
    req1_a = 32'h3FC00000; req1_b = 32'h40000000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req0_valid = (c < 6);
      req1_valid = (c < 6);
      #1;
      for (int d = 0; d < 2; d++) begin
        e0 = (c < 6) && (c % 2 == 0);
        e1 = (c < 6) && (c % 2 == 1);
        total++; if (req0_rdy[d] !== e0 || req1_rdy[d] !== e1) begin bad++; $display("FAIL cont_ready dut%0d c=%0d got=%b%b exp=%b%b", d, c, req0_rdy[d], req1_rdy[d], e0, e1); end
        e0 = (c >= 1) && (c <= 6);
        total++; if (mul_iss[d] !== e0) begin bad++; $display("FAIL cont_issue dut%0d c=%0d got=%b exp=%b", d, c, mul_iss[d], e0); end
        if (e0) begin
          total++; if (mul_a_o[d] !== (((c - 1) % 2 == 1) ? 32'h3FC00000 : 32'h40000000)) begin bad++; $display("FAIL cont_mul_a dut%0d c=%0d got=%h", d, c, mul_a_o[d]); end
        end
        g  = c - LAT[d] - 2;
        e0 = (g >= 0) && (g < 6) && (g % 2 == 0);
        e1 = (g >= 0) && (g < 6) && (g % 2 == 1);
        total++; if (rsp0_v[d] !== e0 || rsp1_v[d] !== e1) begin bad++; $display("FAIL cont_rsp dut%0d c=%0d got=%b%b exp=%b%b", d, c, rsp0_v[d], rsp1_v[d], e0, e1); end
        if (e0) begin
          total++; if (rsp_d[d] !== 32'h40C00000) begin bad++; $display("FAIL cont_data0 dut%0d c=%0d got=%h exp=40C00000", d, c, rsp_d[d]); end
        end
        if (e1) begin
          total++; if (rsp_d[d] !== 32'h40400000) begin bad++; $display("FAIL cont_data1 dut%0d c=%0d got=%h exp=40400000", d, c, rsp_d[d]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   g;
    req0_valid = 1'b0;
    req1_a     = 32'h40000000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req1_valid = (c < 10);
      if (c < 10) req1_b = btab[c];
      #1;
      for (int d = 0; d < 2; d++) begin
        e = (c < 10);
        total++; if (req1_rdy[d] !== e || req0_rdy[d] !== 1'b0) begin bad++; $display("FAIL b2b_ready dut%0d c=%0d got=%b%b exp=0%b", d, c, req0_rdy[d], req1_rdy[d], e); end
        e = (c >= 1) && (c <= 10);
        total++; if (mul_iss[d] !== e) begin bad++; $display("FAIL b2b_issue dut%0d c=%0d got=%b exp=%b", d, c, mul_iss[d], e); end
        g = c - LAT[d] - 2;
        e = (g >= 0) && (g < 10);
        total++; if (rsp1_v[d] !== e || rsp0_v[d] !== 1'b0) begin bad++; $display("FAIL b2b_rsp dut%0d c=%0d got=%b%b exp=0%b", d, c, rsp0_v[d], rsp1_v[d], e); end
        if (e) begin
          total++; if (rsp_d[d] !== etab[g]) begin bad++; $display("FAIL b2b_data dut%0d c=%0d got=%h exp=%h", d, c, rsp_d[d], etab[g]); end
        end
      end
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic e0, e1;
    req0_a = 32'h40000000;
    req1_a = 32'h40000000; req1_b = btab[4];
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      req0_valid = (c <= 10);
      req1_valid = (c >= 3) && (c <= 10);
      drain      = (c >= 3) && (c <= 8);
      if (c < 3) req0_b = btab[c];
      #1;
      e0 = (c < 3);
      e1 = (c == 10);
      total++; if (req0_rdy[0] !== e0 || req1_rdy[0] !== e1) begin bad++; $display("FAIL drain_ready c=%0d got=%b%b exp=%b%b", c, req0_rdy[0], req1_rdy[0], e0, e1); end
      e0 = ((c >= 1) && (c <= 3)) || (c == 11);
      total++; if (mul_iss[0] !== e0) begin bad++; $display("FAIL drain_issue c=%0d got=%b exp=%b", c, mul_iss[0], e0); end
      e0 = (c >= 6) && (c <= 8);
      e1 = (c == 16);
      total++; if (rsp0_v[0] !== e0 || rsp1_v[0] !== e1) begin bad++; $display("FAIL drain_rsp c=%0d got=%b%b exp=%b%b", c, rsp0_v[0], rsp1_v[0], e0, e1); end
      if (e0) begin
        total++; if (rsp_d[0] !== etab[c-6]) begin bad++; $display("FAIL drain_data c=%0d got=%h exp=%h", c, rsp_d[0], etab[c-6]); end
      end
      if (e1) begin
        total++; if (rsp_d[0] !== etab[4]) begin bad++; $display("FAIL drain_resume_data c=%0d got=%h exp=%h", c, rsp_d[0], etab[4]); end
      end
      e0 = (c == 9);
      total++; if (drained_o[0] !== e0) begin bad++; $display("FAIL drain_drained c=%0d got=%b exp=%b", c, drained_o[0], e0); end
      e0 = ((c >= 1) && (c <= 8)) || ((c >= 11) && (c <= 16));
      total++; if (busy_o[0] !== e0) begin bad++; $display("FAIL drain_busy c=%0d got=%b exp=%b", c, busy_o[0], e0); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; drain = 1'b0;
  endtask

  task automatic test_reset_midflight();
    req0_a = 32'h40000000;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      req0_valid = (c < 2);
      req0_b     = btab[c % 10];
      if (c == 2) begin
        total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL midrst_inflight got=%b exp=1", busy_o[0]); end
      end
      if (c == 3) begin
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          total++; if (mul_iss[d] !== 1'b0 || busy_o[d] !== 1'b0 || drained_o[d] !== 1'b0) begin bad++; $display("FAIL midrst_ctrl dut%0d got iss=%b busy=%b drained=%b exp 0", d, mul_iss[d], busy_o[d], drained_o[d]); end
          total++; if (rsp0_v[d] !== 1'b0 || rsp1_v[d] !== 1'b0) begin bad++; $display("FAIL midrst_rsp dut%0d got=%b%b exp=00", d, rsp0_v[d], rsp1_v[d]); end
          total++; if (mul_a_o[d] !== 32'h0 || mul_b_o[d] !== 32'h0 || rsp_d[d] !== 32'h0) begin bad++; $display("FAIL midrst_data dut%0d got a=%h b=%h r=%h exp 0", d, mul_a_o[d], mul_b_o[d], rsp_d[d]); end
        end
      end
      if (c == 4) rst_n = 1'b1;
      if (c >= 4) begin
        #1;
        for (int d = 0; d < 2; d++) begin
          total++; if (rsp0_v[d] !== 1'b0 || rsp1_v[d] !== 1'b0 || busy_o[d] !== 1'b0) begin bad++; $display("FAIL midrst_after dut%0d c=%0d got rsp=%b%b busy=%b exp 0", d, c, rsp0_v[d], rsp1_v[d], busy_o[d]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_drain();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
